// File: rtl/fetch_mem_ctrl_pkg.sv
// Shared constants and state encoding for the fetch/load-store memory controller.
package fetch_mem_ctrl_pkg;
    localparam int   ADDR_LEN     = 32;
    localparam int   REG_LEN      = 32;
    localparam int   CACHE_LEN    = 7;
    localparam int   TAG_LEN      = ADDR_LEN - CACHE_LEN - 2;
    localparam int   CACHE_SIZE   = 1 << CACHE_LEN;
    localparam logic RESET_ENABLE = 1'b1;
    localparam logic VALID        = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        LS_RD = 2'd2,
        LS_WR = 2'd3
    } state_e;
endpackage

// File: rtl/fetch_mem_ctrl_if.sv
// Pipeline-side (IF, MEM) and RAM-side signals of the memory controller.
interface fetch_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_pc;
    logic              if_ready;
    logic [DATA_W-1:0] if_inst;
    logic              flush;
    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [1:0]        ls_len;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_done;
    logic [DATA_W-1:0] ls_rdata;
    logic [ADDR_W-1:0] mem_a;
    logic [7:0]        mem_dout;
    logic [7:0]        mem_din;
    logic              mem_wr;

    modport slave (
        input  if_req, if_pc, flush, ls_req, ls_we, ls_addr, ls_len, ls_wdata, mem_din,
        output if_ready, if_inst, ls_done, ls_rdata, mem_a, mem_dout, mem_wr
    );
    modport master (
        output if_req, if_pc, flush, ls_req, ls_we, ls_addr, ls_len, ls_wdata, mem_din,
        input  if_ready, if_inst, ls_done, ls_rdata, mem_a, mem_dout, mem_wr
    );
endinterface

// File: rtl/fetch_mem_ctrl_icache.sv
// Direct-mapped instruction cache: combinational lookup, single-word line replace.
module fetch_mem_ctrl_icache
    import fetch_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_LEN,
    parameter int DATA_W = REG_LEN,
    parameter int IDX_W  = CACHE_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              replace_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] rdata_o
);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam int SIZE  = 1 << IDX_W;

    logic [SIZE-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SIZE];
    logic [DATA_W-1:0] data_q [SIZE];
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;

    assign idx     = addr_i[IDX_W+1:2];
    assign tag     = addr_i[ADDR_W-1:IDX_W+2];
    assign hit_o   = valid_q[idx] && (tag_q[idx] == tag);
    assign rdata_o = data_q[idx];

    always_ff @(posedge clk) begin
        if (rst == RESET_ENABLE) valid_q <= '0;
        else if (replace_i)      valid_q[idx] <= VALID;
    end

    // Tag/data need no reset: valid_q gates every lookup.
    always_ff @(posedge clk) begin
        if (replace_i) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= wdata_i;
        end
    end
endmodule

// File: rtl/fetch_mem_ctrl.sv
// Arbitrates the byte-wide RAM between instruction refills and load/store traffic.
module fetch_mem_ctrl
    import fetch_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W      = ADDR_LEN,
    parameter int DATA_W      = REG_LEN,
    parameter int CACHE_IDX_W = CACHE_LEN
) (
    input  logic      clk,
    input  logic      rst,
    fetch_mem_if.slave bus
);
    state_e            state_q;
    logic [2:0]        cnt_q, n_q;
    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] wdata_q, buf_q, if_inst_q, ls_rdata_q;
    logic              if_ready_q, ls_done_q;

    logic [DATA_W-1:0] word_d, cache_rdata;
    logic [ADDR_W-1:0] cache_addr;
    logic [1:0]        bsel;
    logic              cache_hit, rd_done, replace, active;

    // Byte c-1 arrives on mem_din while the counter shows c.
    always_comb begin
        bsel   = 2'(cnt_q - 3'd1);
        word_d = buf_q;
        if (cnt_q != 3'd0) word_d[{bsel, 3'b000} +: 8] = bus.mem_din;
    end

    assign rd_done    = (state_q == IF_RD || state_q == LS_RD) && (cnt_q == n_q);
    assign replace    = (state_q == IF_RD) && rd_done && !bus.flush && !rst;
    assign active     = (state_q != IDLE) && (cnt_q < n_q);
    assign cache_addr = (state_q == IF_RD) ? base_q : bus.if_pc;

    assign bus.mem_a    = active ? base_q + ADDR_W'(cnt_q) : '0;
    assign bus.mem_wr   = (state_q == LS_WR);
    assign bus.mem_dout = (state_q == LS_WR) ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;
    assign bus.if_ready = if_ready_q;
    assign bus.if_inst  = if_inst_q;
    assign bus.ls_done  = ls_done_q;
    assign bus.ls_rdata = ls_rdata_q;

    fetch_mem_ctrl_icache #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(CACHE_IDX_W)
    ) u_icache (
        .clk      (clk),
        .rst      (rst),
        .addr_i   (cache_addr),
        .replace_i(replace),
        .wdata_i  (word_d),
        .hit_o    (cache_hit),
        .rdata_o  (cache_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst == RESET_ENABLE) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            n_q        <= '0;
            base_q     <= '0;
            wdata_q    <= '0;
            buf_q      <= '0;
            if_inst_q  <= '0;
            ls_rdata_q <= '0;
            if_ready_q <= 1'b0;
            ls_done_q  <= 1'b0;
        end else begin
            if_ready_q <= 1'b0;
            ls_done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    buf_q <= '0;
                    if (bus.ls_req) begin
                        base_q  <= bus.ls_addr;
                        n_q     <= {1'b0, bus.ls_len} + 3'd1;
                        wdata_q <= bus.ls_wdata;
                        state_q <= bus.ls_we ? LS_WR : LS_RD;
                    end else if (bus.if_req && !bus.flush) begin
                        if (cache_hit) begin
                            if_inst_q  <= cache_rdata;
                            if_ready_q <= 1'b1;
                        end else begin
                            base_q  <= bus.if_pc;
                            n_q     <= 3'd4;
                            state_q <= IF_RD;
                        end
                    end
                end
                IF_RD: begin
                    if (bus.flush) begin
                        state_q <= IDLE;
                    end else if (rd_done) begin
                        if_inst_q  <= word_d;
                        if_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        buf_q <= word_d;
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                LS_RD: begin
                    if (rd_done) begin
                        ls_rdata_q <= word_d;
                        ls_done_q  <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        buf_q <= word_d;
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                LS_WR: begin
                    if (cnt_q == n_q - 3'd1) begin
                        ls_done_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_mem_ctrl.sv
// Scoreboard bench: drivers queue expected pulses, a negedge monitor pops and compares.
module tb_fetch_mem_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_mem_if bus ();
    fetch_mem_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    // RAM: preload image (initial only) plus store overlay (RAM process only)
    logic [7:0] rom  [int];
    logic [7:0] wmem [int];
    function automatic logic [7:0] rd_byte(input int a);
        if (wmem.exists(a)) return wmem[a];
        if (rom.exists(a))  return rom[a];
        return 8'h00;
    endfunction
    always @(posedge clk) begin
        bus.mem_din <= rd_byte(int'(bus.mem_a));
        if (bus.mem_wr) wmem[int'(bus.mem_a)] = bus.mem_dout;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit is_ls; bit chk; logic [31:0] data; int at; } exp_t;
    exp_t sb[$];
    logic [31:0] rd_log[$];
    logic [31:0] wa_log[$];
    logic [7:0]  wd_log[$];
    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic pop_cmp(input bit is_ls, input logic [31:0] data);
        int idx = -1;
        for (int i = 0; i < sb.size(); i++)
            if (sb[i].is_ls == is_ls) begin idx = i; break; end
        if (idx < 0) begin
            chk(is_ls ? "unexpected_ls_done" : "unexpected_if_ready", 32'd1, 32'd0);
        end else begin
            exp_t e = sb[idx];
            sb.delete(idx);
            chk(is_ls ? "ls_done_cycle" : "if_ready_cycle", cyc, e.at);
            if (e.chk) chk(is_ls ? "ls_rdata" : "if_inst", data, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_wr === 1'b1) begin
            wa_log.push_back(bus.mem_a);
            wd_log.push_back(bus.mem_dout);
        end else if (bus.mem_a !== 32'h0 && !rst) begin
            rd_log.push_back(bus.mem_a);
        end
        if (bus.if_ready === 1'b1 && bus.ls_done === 1'b1) chk("both_pulses", 32'd1, 32'd0);
        if (bus.if_ready === 1'b1) pop_cmp(1'b0, bus.if_inst);
        if (bus.ls_done === 1'b1)  pop_cmp(1'b1, bus.ls_rdata);
    end

    task automatic wait_pulse(input bit is_ls, input string nm);
        bit got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((is_ls ? bus.ls_done : bus.if_ready) === 1'b1) begin got = 1'b1; break; end
        end
        if (!got) chk(nm, 32'd0, 32'd1);
    endtask

    task automatic fetch(input logic [31:0] pc, input int lat, input logic [31:0] ev);
        @(negedge clk);
        bus.if_req = 1'b1;
        bus.if_pc  = pc;
        sb.push_back('{1'b0, 1'b1, ev, cyc + lat});
        wait_pulse(1'b0, "fetch_timeout");
        bus.if_req = 1'b0;
    endtask

    task automatic ls_op(input bit we, input logic [31:0] a, input logic [1:0] len,
                         input logic [31:0] wd, input int lat, input logic [31:0] ev);
        @(negedge clk);
        bus.ls_req   = 1'b1;
        bus.ls_we    = we;
        bus.ls_addr  = a;
        bus.ls_len   = len;
        bus.ls_wdata = wd;
        sb.push_back('{1'b1, !we, ev, cyc + lat});
        wait_pulse(1'b1, "ls_timeout");
        bus.ls_req = 1'b0;
    endtask

    task automatic clear_logs();
        rd_log.delete(); wa_log.delete(); wd_log.delete();
    endtask

    initial begin
        rom[32'h100] = 8'h13; rom[32'h101] = 8'h05; rom[32'h102] = 8'h00; rom[32'h103] = 8'h00;
        rom[32'h300] = 8'h93; rom[32'h301] = 8'h00; rom[32'h302] = 8'h10; rom[32'h303] = 8'h00;
        rom[32'h200] = 8'h67; rom[32'h201] = 8'h80; rom[32'h202] = 8'h00; rom[32'h203] = 8'h00;
        rom[32'h400] = 8'h37; rom[32'h401] = 8'h01; rom[32'h402] = 8'h00; rom[32'h403] = 8'h00;
        rom[32'h1000] = 8'h11; rom[32'h1003] = 8'h44;

        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_pc = '0; bus.flush = 1'b0;
        bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_len = '0; bus.ls_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_if_ready", {31'd0, bus.if_ready}, 32'd0);
        chk("rst_ls_done",  {31'd0, bus.ls_done},  32'd0);
        chk("rst_mem_wr",   {31'd0, bus.mem_wr},   32'd0);
        chk("rst_mem_a",    bus.mem_a,             32'd0);
        chk("rst_mem_dout", {24'd0, bus.mem_dout}, 32'd0);
        chk("rst_if_inst",  bus.if_inst,           32'd0);
        chk("rst_ls_rdata", bus.ls_rdata,          32'd0);
        rst = 1'b0;

        // cold miss, then hit, then alias eviction
        clear_logs();
        fetch(32'h100, 6, 32'h00000513);
        chk("cold_reads", rd_log.size(), 32'd4);
        if (rd_log.size() == 4) begin
            chk("cold_a0", rd_log[0], 32'h100);
            chk("cold_a3", rd_log[3], 32'h103);
        end
        clear_logs();
        fetch(32'h100, 1, 32'h00000513);
        chk("hit_no_ram", rd_log.size(), 32'd0);
        fetch(32'h300, 6, 32'h00100093);
        clear_logs();
        fetch(32'h100, 6, 32'h00000513);
        chk("evicted_reads", rd_log.size(), 32'd4);

        // stores and loads
        clear_logs();
        ls_op(1'b1, 32'h1001, 2'd1, 32'h0000BEEF, 3, 32'h0);
        chk("st_count", wa_log.size(), 32'd2);
        if (wa_log.size() == 2) begin
            chk("st_a0", wa_log[0], 32'h1001); chk("st_d0", {24'd0, wd_log[0]}, 32'hEF);
            chk("st_a1", wa_log[1], 32'h1002); chk("st_d1", {24'd0, wd_log[1]}, 32'hBE);
        end
        ls_op(1'b0, 32'h1001, 2'd1, 32'h0, 4, 32'h0000BEEF);
        ls_op(1'b0, 32'h1000, 2'd3, 32'h0, 6, 32'h44BEEF11);
        ls_op(1'b0, 32'h1003, 2'd0, 32'h0, 3, 32'h00000044);
        ls_op(1'b1, 32'h2000, 2'd3, 32'hCAFEF00D, 5, 32'h0);
        ls_op(1'b0, 32'h2000, 2'd3, 32'h0, 6, 32'hCAFEF00D);

        // LS wins over a simultaneous IF miss; refill follows ls_done
        fork
            ls_op(1'b0, 32'h1001, 2'd1, 32'h0, 4, 32'h0000BEEF);
            fetch(32'h200, 10, 32'h00008067);
        join

        // flush two cycles into a refill
        begin
            int seen = 0;
            @(negedge clk); bus.if_req = 1'b1; bus.if_pc = 32'h400;
            @(negedge clk);
            @(negedge clk); bus.flush = 1'b1; bus.if_req = 1'b0;
            @(negedge clk); bus.flush = 1'b0;
            repeat (10) begin @(negedge clk); if (bus.if_ready === 1'b1) seen++; end
            chk("flush_no_ready", seen, 32'd0);
        end
        clear_logs();
        fetch(32'h400, 6, 32'h00000137);
        chk("flush_refetch_miss", rd_log.size(), 32'd4);

        // reset in the middle of a 4-byte store
        clear_logs();
        @(negedge clk);
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h3000;
        bus.ls_len = 2'd3; bus.ls_wdata = 32'h12345678;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_mem_wr",  {31'd0, bus.mem_wr},  32'd0);
        chk("rst_mid_ls_done", {31'd0, bus.ls_done}, 32'd0);
        chk("rst_mid_if_inst", bus.if_inst, 32'd0);
        rst = 1'b0; bus.ls_req = 1'b0;
        begin
            int seen = 0;
            repeat (8) begin @(negedge clk); if (bus.ls_done === 1'b1) seen++; end
            chk("rst_no_done", seen, 32'd0);
        end
        chk("rst_partial_writes", wa_log.size(), 32'd2);
        clear_logs();
        fetch(32'h100, 6, 32'h00000513);
        chk("rst_cache_cold", rd_log.size(), 32'd4);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
